// File: rtl/video_sig_gen.sv
// Raster timing generator: hcount/vcount coordinates, sync/active strobes,
// new-frame pulse and frame counter, all registered and mutually aligned.
module video_sig_gen #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int H_FRONT_PORCH   = 110,
  parameter int H_SYNC_WIDTH    = 40,
  parameter int H_BACK_PORCH    = 220,
  parameter int ACTIVE_LINES    = 720,
  parameter int V_FRONT_PORCH   = 5,
  parameter int V_SYNC_WIDTH    = 5,
  parameter int V_BACK_PORCH    = 20,
  parameter int FPS             = 60
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out
);

  localparam int H_TOTAL = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int V_TOTAL = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(ACTIVE_H_PIXELS);
  localparam logic [10:0] HS_START   = 11'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
  localparam logic [10:0] HS_END     = 11'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT      = 10'(ACTIVE_LINES);
  localparam logic [9:0]  VS_START   = 10'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [9:0]  VS_END     = 10'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);
  localparam logic [5:0]  FC_LAST    = 6'(FPS - 1);

  logic        r_running;
  logic [10:0] w_h_next;
  logic [9:0]  w_v_next;
  logic        w_ad_next;
  logic        w_hs_next;
  logic        w_vs_next;
  logic        w_nf_next;

  // The first edge after reset only arms the generator, so (0,0) is held for it.
  always_comb begin
    w_h_next = '0;
    w_v_next = '0;
    if (r_running) begin
      if (hcount_out == H_LAST) begin
        w_h_next = '0;
        w_v_next = (vcount_out == V_LAST) ? 10'd0 : vcount_out + 10'd1;
      end else begin
        w_h_next = hcount_out + 11'd1;
        w_v_next = vcount_out;
      end
    end
  end

  assign w_ad_next = (w_h_next < H_ACT) && (w_v_next < V_ACT);
  assign w_hs_next = (w_h_next >= HS_START) && (w_h_next < HS_END);
  assign w_vs_next = (w_v_next >= VS_START) && (w_v_next < VS_END);
  assign w_nf_next = (w_h_next == H_ACT) && (w_v_next == V_ACT);

  // Strobes are decoded from the next coordinate so they land with it.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_running  <= 1'b0;
      hcount_out <= '0;
      vcount_out <= '0;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      ad_out     <= 1'b0;
      nf_out     <= 1'b0;
      fc_out     <= '0;
    end else begin
      r_running  <= 1'b1;
      hcount_out <= w_h_next;
      vcount_out <= w_v_next;
      hs_out     <= w_hs_next;
      vs_out     <= w_vs_next;
      ad_out     <= w_ad_next;
      nf_out     <= w_nf_next;
      if (w_nf_next) begin
        fc_out <= (fc_out == FC_LAST) ? 6'd0 : fc_out + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_sig_gen.sv
// Randomized bench for video_sig_gen: a 720p instance and a tiny-raster instance
// share clock and reset and are compared every cycle against a linear-index model.
module tb_video_sig_gen;

  logic        clk;
  logic        rst;

  logic [10:0] hd_h;
  logic [9:0]  hd_v;
  logic        hd_hs, hd_vs, hd_ad, hd_nf;
  logic [5:0]  hd_fc;

  logic [10:0] sm_h;
  logic [9:0]  sm_v;
  logic        sm_hs, sm_vs, sm_ad, sm_nf;
  logic [5:0]  sm_fc;

  int     n_checks = 0;
  int     n_errors = 0;
  longint k = 0;
  longint last_nf = -1;

  typedef struct packed {
    longint h, v, hs, vs, ad, nf, fc;
  } exp_t;

  video_sig_gen dut_hd (
    .pixel_clk_in(clk), .rst_in(rst),
    .hcount_out(hd_h), .vcount_out(hd_v), .hs_out(hd_hs), .vs_out(hd_vs),
    .ad_out(hd_ad), .nf_out(hd_nf), .fc_out(hd_fc)
  );

  video_sig_gen #(
    .ACTIVE_H_PIXELS(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(2), .H_BACK_PORCH(2),
    .ACTIVE_LINES(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1), .V_BACK_PORCH(1),
    .FPS(3)
  ) dut_sm (
    .pixel_clk_in(clk), .rst_in(rst),
    .hcount_out(sm_h), .vcount_out(sm_v), .hs_out(sm_hs), .vs_out(sm_vs),
    .ad_out(sm_ad), .nf_out(sm_nf), .fc_out(sm_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, k);
    end
  endtask

  // k = rising edges since reset release (0 while in reset). Edge k shows raster
  // position k-1 of an endless sequence of frames; fc counts nf positions passed.
  function automatic exp_t model(longint kk, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb, int fps);
    exp_t   e;
    longint ht, vt, ft, idx, pos, nfidx;
    e = '0;
    if (kk == 0) return e;
    ht    = ha + hf + hsw + hb;
    vt    = va + vf + vsw + vb;
    ft    = ht * vt;
    idx   = kk - 1;
    pos   = idx % ft;
    e.h   = pos % ht;
    e.v   = pos / ht;
    e.ad  = (e.h < ha && e.v < va) ? 1 : 0;
    e.hs  = (e.h >= ha + hf && e.h < ha + hf + hsw) ? 1 : 0;
    e.vs  = (e.v >= va + vf && e.v < va + vf + vsw) ? 1 : 0;
    e.nf  = (e.h == ha && e.v == va) ? 1 : 0;
    nfidx = longint'(va) * ht + ha;
    e.fc  = (idx >= nfidx) ? (((idx - nfidx) / ft) + 1) % fps : 0;
    return e;
  endfunction

  task automatic check_all();
    exp_t e;
    e = model(k, 1280, 110, 40, 220, 720, 5, 5, 20, 60);
    check("hd.hcount", hd_h, e.h);
    check("hd.vcount", hd_v, e.v);
    check("hd.hs", hd_hs, e.hs);
    check("hd.vs", hd_vs, e.vs);
    check("hd.ad", hd_ad, e.ad);
    check("hd.nf", hd_nf, e.nf);
    check("hd.fc", hd_fc, e.fc);
    e = model(k, 8, 2, 2, 2, 4, 1, 1, 1, 3);
    check("sm.hcount", sm_h, e.h);
    check("sm.vcount", sm_v, e.v);
    check("sm.hs", sm_hs, e.hs);
    check("sm.vs", sm_vs, e.vs);
    check("sm.ad", sm_ad, e.ad);
    check("sm.nf", sm_nf, e.nf);
    check("sm.fc", sm_fc, e.fc);
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) k++;
    check_all();
    if (!rst && sm_nf) begin
      if (last_nf >= 0) check("sm.nf_period", k - last_nf, 98);
      last_nf = k;
    end
  endtask

  // Called just after a negedge sample: reset lands between edges.
  task automatic async_reset(input int hold);
    #1 rst = 1'b1;
    #1;
    k = 0;
    last_nf = -1;
    check_all();
    for (int i = 0; i < hold; i++) step();
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b0;

    // Covers 720p lines 0..2 including hs window and the 1649->0 wrap,
    // and many small frames including fc wrap and nf spacing.
    for (int i = 0; i < 3400; i++) step();

    for (int it = 0; it < 4; it++) begin
      int run = int'($urandom_range(50, 400));
      for (int i = 0; i < run; i++) step();
      async_reset(int'($urandom_range(0, 3)));
    end

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (sm_hs && sm_vs) found = 1'b1;
    end
    check("sm.sync_found", found, 1);
    async_reset(2);

    for (int i = 0; i < 400; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
